// File: rtl/ins_mem_pkg.sv
// Shared constants for the instruction memory: default widths, the boot image
// that reset reloads, and the NOP fill word.
package ins_mem_pkg;
    localparam int DATA_W_DFLT = 16;
    localparam int ADDR_W_DFLT = 16;
    localparam int BOOT_LEN    = 4;

    localparam logic [DATA_W_DFLT-1:0] NOP_WORD = 16'h0000;

    // Element 0 is the word loaded at address 0.
    localparam logic [BOOT_LEN-1:0][DATA_W_DFLT-1:0] BOOT_IMAGE =
        {16'h4404, 16'h3303, 16'h2202, 16'h1101};

    function automatic logic [DATA_W_DFLT-1:0] boot_word(input int idx);
        logic [DATA_W_DFLT-1:0] w;
        w = NOP_WORD;
        for (int i = 0; i < BOOT_LEN; i++) begin
            if (i == idx) begin
                w = BOOT_IMAGE[i];
            end
        end
        return w;
    endfunction
endpackage

// File: rtl/ins_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port,
// plus a whole-array boot load that overrides the write port.
module ins_mem_array
    import ins_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              boot,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (boot) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(boot_word(i));
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ins_mem.sv
// Word-addressed instruction memory with combinational fetch, a program-load
// write port, and a boot image restored on every synchronous reset.
module ins_mem
    import ins_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addrss,
    output logic [DATA_W-1:0] data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              addr_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    logic              rd_ok;
    logic              wr_ok;
    logic [DATA_W-1:0] rdata;

    assign rd_ok = ({1'b0, addrss} < DEPTH_A);
    // Reset wins over a coincident write; out-of-range writes vanish silently.
    assign wr_ok = wr_en && !rst && ({1'b0, wr_addr} < DEPTH_A);

    ins_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .boot  (rst),
        .we    (wr_ok),
        .waddr (wr_addr[IDX_W-1:0]),
        .wdata (wr_data),
        .raddr (addrss[IDX_W-1:0]),
        .rdata (rdata)
    );

    assign data     = rd_ok ? rdata : '0;
    assign addr_err = !rd_ok;
endmodule

// File: tb/tb_ins_mem.sv
// Directed bench for ins_mem: boot image, range checks, program load, reset priority.
module tb_ins_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addrss;
    logic [15:0] data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    ins_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .addrss   (addrss),
        .data     (data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        addrss  = 16'd0;
        wr_en   = 1'b0;
        wr_addr = 16'd0;
        wr_data = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("boot0",     data, 16'h1101);
        chk("boot0_err", {15'd0, addr_err}, 16'd0);

        addrss = 16'd1; #100;
        chk("boot1", data, 16'h2202);
        chk("boot1_err", {15'd0, addr_err}, 16'd0);
        addrss = 16'd2; #100;
        chk("boot2", data, 16'h3303);
        addrss = 16'd3; #100;
        chk("boot3", data, 16'h4404);
        chk("boot3_err", {15'd0, addr_err}, 16'd0);

        addrss = 16'd4; #1;
        chk("nop4", data, 16'h0000);
        chk("nop4_err", {15'd0, addr_err}, 16'd0);
        addrss = 16'd255; #1;
        chk("last_err", {15'd0, addr_err}, 16'd0);
        addrss = 16'd256; #1;
        chk("oob_data", data, 16'h0000);
        chk("oob_err", {15'd0, addr_err}, 16'd1);
        addrss = 16'hFFFF; #1;
        chk("max_err", {15'd0, addr_err}, 16'd1);

        @(negedge clk);
        addrss  = 16'd5;
        wr_en   = 1'b1;
        wr_addr = 16'd5;
        wr_data = 16'hBEEF;
        #1;
        chk("wr5_before", data, 16'h0000);
        tick();
        wr_en = 1'b0;
        chk("wr5_after", data, 16'hBEEF);

        wr_en   = 1'b1;
        wr_addr = 16'h0100;
        wr_data = 16'hDEAD;
        tick();
        wr_en  = 1'b0;
        addrss = 16'd0; #1;
        chk("oobwr_w0", data, 16'h1101);
        addrss = 16'd255; #1;
        chk("oobwr_w255", data, 16'h0000);
        addrss = 16'd5; #1;
        chk("oobwr_w5", data, 16'hBEEF);

        wr_addr = 16'd5;
        wr_data = 16'h1234;
        tick();
        chk("noen_w5", data, 16'hBEEF);

        wr_en   = 1'b1;
        wr_addr = 16'd255;
        wr_data = 16'h5A5A;
        tick();
        wr_en  = 1'b0;
        addrss = 16'd255; #1;
        chk("wr255", data, 16'h5A5A);

        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 16'd1;
        wr_data = 16'hFFFF;
        tick();
        rst    = 1'b0;
        wr_en  = 1'b0;
        addrss = 16'd1; #1;
        chk("rstpri_w1", data, 16'h2202);
        addrss = 16'd5; #1;
        chk("rstclr_w5", data, 16'h0000);
        addrss = 16'd255; #1;
        chk("rstclr_w255", data, 16'h0000);

        wr_en   = 1'b1;
        wr_addr = 16'd2;
        wr_data = 16'hAAAA;
        tick();
        wr_en  = 1'b0;
        addrss = 16'd2; #1;
        chk("wr2", data, 16'hAAAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_w2", data, 16'h3303);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ins_mem.md
INS_MEM -- requirements
Module: ins_mem

Interface
REQ-001 Parameter DATA_W, default 16: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 16: address width in bits.
REQ-003 Parameter DEPTH, default 256: number of implemented words, must be ≤ 2^ADDR_W.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: rising-edge clock for all state.
REQ-006 Port rst, input, 1: synchronous active-high reset; reloads the boot image.
REQ-007 Port addrss, input, ADDR_W: word address of the instruction fetch.
REQ-008 Port data, output, DATA_W: instruction word at addrss.
REQ-009 Port wr_en, input, 1: program-load write enable.
REQ-010 Port wr_addr, input, ADDR_W: program-load word address.
REQ-011 Port wr_data, input, DATA_W: program-load word.
REQ-012 Port addr_err, output, 1: high when addrss ≥ DEPTH.

Function
REQ-013 Memory SHALL be word-addressed: address N selects word N, with no byte offset.
REQ-014 Read SHALL be combinational: data follows addrss and the current contents within the same cycle, with zero clock latency.
REQ-015 addrss ≥ DEPTH SHALL drive data=0 and addr_err=1; otherwise addr_err=0.
REQ-016 With wr_en=1, rst=0 and wr_addr < DEPTH, mem[wr_addr] SHALL take wr_data at the rising clk edge.
REQ-017 Writes with wr_addr ≥ DEPTH SHALL be ignored without error.
REQ-018 Read and write to the same address in one cycle: data SHALL show the old word before the edge and the new word after it; there is no write-through bypass.
REQ-019 wr_en=0 SHALL leave contents unchanged.
REQ-020 data and addr_err SHALL never be X once reset has been applied at least once.

Reset
REQ-021 On a rising clk with rst=1, words 0..3 SHALL load the boot image 0x1101, 0x2202, 0x3303, 0x4404.
REQ-022 On the same reset edge, words 4..DEPTH-1 SHALL load 0x0000.
REQ-023 Reset SHALL take priority over a simultaneous write; the write is dropped.
REQ-024 Reset asserted in the middle of a program load SHALL discard all prior writes and restore the boot image.
REQ-025 Outputs have no registered reset value: after reset, data equals the boot word at addrss; for example, addrss=0 gives 0x1101.

Structure
REQ-026 A shared package ins_mem_pkg SHALL hold DATA_W and ADDR_W defaults, the BOOT_IMAGE constant array (4 words), BOOT_LEN=4 and the NOP word 0x0000.
REQ-027 A single sub-module, ins_mem_array, SHALL implement the DEPTH×DATA_W storage with one synchronous write port and one asynchronous read port.
REQ-028 The top module SHALL contain the address-range checks, the reset/boot-load sequencing and the output muxing.

Verification
REQ-029 Reset, then rst=0 with addrss stepped 0,1,2,3 at 100 ns intervals -> data = 0x1101, 0x2202, 0x3303, 0x4404, with addr_err=0 throughout.
REQ-030 After reset, addrss=4 -> data=0x0000 and addr_err=0; addrss=DEPTH (256) -> data=0x0000 and addr_err=1.
REQ-031 Write wr_addr=5, wr_data=0xBEEF; then addrss=5 -> data=0xBEEF after the edge, and the prior value 0x0000 before the edge.
REQ-032 Write wr_addr=0x0100, wr_data=0xDEAD -> no change to any word; addrss=0 still gives data=0x1101.
REQ-033 Assert rst and wr_en together with wr_addr=1, wr_data=0xFFFF -> addrss=1 gives data=0x2202.
REQ-034 Write 0xAAAA to address 2, then reset -> addrss=2 gives data=0x3303.
